// File: rtl/ui_polyline_drawer_if.sv
// Command and pixel-write bundle for the polyline drawer.
// The master side is the UI client issuing strokes and consuming pixel writes;
// the slave side is the drawer itself.
interface ui_polyline_drawer_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3,
    parameter int NUM_SEG = 4,
    parameter int LEN_W   = 5
);
    localparam int SEG_W = $clog2(NUM_SEG + 1);

    // Command side
    logic                     start;
    logic                     abort;
    logic                     erase;
    logic [COLOR_W-1:0]       fg_color;
    logic [X_W-1:0]           x0;
    logic [Y_W-1:0]           y0;
    logic [SEG_W-1:0]         num_seg;
    logic [3*NUM_SEG-1:0]     seg_dir;
    logic [LEN_W*NUM_SEG-1:0] seg_len;

    // Pixel-write and status side
    logic [X_W-1:0]           x;
    logic [Y_W-1:0]           y;
    logic [COLOR_W-1:0]       color;
    logic                     plot;
    logic                     busy;
    logic                     done;

    modport master (
        output start, abort, erase, fg_color, x0, y0, num_seg, seg_dir, seg_len,
        input  x, y, color, plot, busy, done
    );

    modport slave (
        input  start, abort, erase, fg_color, x0, y0, num_seg, seg_dir, seg_len,
        output x, y, color, plot, busy, done
    );
endinterface

// File: rtl/ui_polyline_drawer.sv
// Frame-paced polyline stroke renderer for the 160x120 UI layer.
// Plots the origin, then walks up to NUM_SEG straight segments in one of
// eight directions, emitting one pixel write per step, spaced STEP_DIV
// clocks apart. Coordinates wrap modulo the coordinate width.
module ui_polyline_drawer #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = 3,
    parameter int NUM_SEG  = 4,
    parameter int LEN_W    = 5,
    parameter int STEP_DIV = 1
) (
    input logic                clk,
    input logic                reset_n,
    ui_polyline_drawer_if.slave bus
);
    localparam int SEG_W = $clog2(NUM_SEG + 1);
    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_ORIGIN, S_SEG, S_FIN} state_t;

    state_t                   state_q;
    state_t                   state_d;

    // Stroke parameters captured at start
    logic [SEG_W-1:0]         num_seg_q;
    logic [3*NUM_SEG-1:0]     dir_q;
    logic [LEN_W*NUM_SEG-1:0] len_q;
    logic [COLOR_W-1:0]       color_q;

    // Walk state
    logic [X_W-1:0]           pos_x_q;
    logic [Y_W-1:0]           pos_y_q;
    logic [SEG_W-1:0]         idx_q;
    logic [LEN_W-1:0]         rem_q;
    logic [DIV_W-1:0]         div_q;

    // Derived step controls
    logic                     seg_tick;
    logic                     step_go;
    logic                     skip_go;
    logic                     seg_last;
    logic                     advance;
    logic                     last_seg;
    logic [SEG_W-1:0]         idx_nxt;
    logic [2:0]               cur_dir;
    logic signed [1:0]        dx;
    logic signed [1:0]        dy;
    logic [X_W-1:0]           step_x;
    logic [Y_W-1:0]           step_y;

    // Output drivers
    logic [X_W-1:0]           pix_x;
    logic [Y_W-1:0]           pix_y;
    logic                     pix_plot;
    logic                     busy_o;
    logic                     done_o;

    // Length of segment i; indices past the table read as zero.
    function automatic logic [LEN_W-1:0] len_at(input logic [LEN_W*NUM_SEG-1:0] lens,
                                                input logic [SEG_W-1:0] i);
        logic [LEN_W-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_SEG; k++) begin
            if (i == SEG_W'(k)) r = lens[k*LEN_W +: LEN_W];
        end
        return r;
    endfunction

    // Direction code of segment i.
    function automatic logic [2:0] dir_at(input logic [3*NUM_SEG-1:0] dirs,
                                          input logic [SEG_W-1:0] i);
        logic [2:0] r;
        r = '0;
        for (int k = 0; k < NUM_SEG; k++) begin
            if (i == SEG_W'(k)) r = dirs[k*3 +: 3];
        end
        return r;
    endfunction

    // x step for a direction: E, NE, SE move right; NW, W, SW move left.
    function automatic logic signed [1:0] dir_dx(input logic [2:0] d);
        case (d)
            3'd0, 3'd1, 3'd7: return 2'sb01;
            3'd3, 3'd4, 3'd5: return 2'sb11;
            default:          return 2'sb00;
        endcase
    endfunction

    // y step for a direction: y grows downward, so N-ward moves are -1.
    function automatic logic signed [1:0] dir_dy(input logic [2:0] d);
        case (d)
            3'd1, 3'd2, 3'd3: return 2'sb11;
            3'd5, 3'd6, 3'd7: return 2'sb01;
            default:          return 2'sb00;
        endcase
    endfunction

    // Step decode: a segment action happens only when the divider reaches zero.
    // Abort suppresses both plotting and index advance in its cycle.
    always_comb begin
        seg_tick = (state_q == S_SEG) && (div_q == '0);
        step_go  = seg_tick && (rem_q != '0) && !bus.abort;
        skip_go  = seg_tick && (rem_q == '0) && !bus.abort;
        seg_last = step_go && (rem_q == LEN_W'(1));
        advance  = skip_go || seg_last;
        idx_nxt  = idx_q + SEG_W'(1);
        last_seg = (idx_nxt == num_seg_q);
        cur_dir  = dir_at(dir_q, idx_q);
        dx       = dir_dx(cur_dir);
        dy       = dir_dy(cur_dir);
        step_x   = pos_x_q + {{(X_W-1){dx[1]}}, dx[0]};
        step_y   = pos_y_q + {{(Y_W-1){dy[1]}}, dy[0]};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_ORIGIN;
            end
            S_ORIGIN: begin
                if (bus.abort)              state_d = S_IDLE;
                else if (num_seg_q == '0)   state_d = S_FIN;
                else                        state_d = S_SEG;
            end
            S_SEG: begin
                if (bus.abort)              state_d = S_IDLE;
                else if (advance && last_seg) state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: plot strobes the origin once, then each stepped pixel;
    // x/y show the pixel being written and otherwise hold the last one.
    always_comb begin
        pix_plot = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        pix_x    = pos_x_q;
        pix_y    = pos_y_q;
        case (state_q)
            S_ORIGIN: begin
                busy_o   = 1'b1;
                pix_plot = !bus.abort;
            end
            S_SEG: begin
                busy_o = 1'b1;
                if (step_go) begin
                    pix_plot = 1'b1;
                    pix_x    = step_x;
                    pix_y    = step_y;
                end
            end
            S_FIN: begin
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Stroke capture and walk datapath.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pos_x_q <= '0;
            pos_y_q <= '0;
            color_q <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        pos_x_q   <= bus.x0;
                        pos_y_q   <= bus.y0;
                        color_q   <= bus.erase ? '0 : bus.fg_color;
                        num_seg_q <= bus.num_seg;
                        dir_q     <= bus.seg_dir;
                        len_q     <= bus.seg_len;
                    end
                end
                S_ORIGIN: begin
                    idx_q <= '0;
                    rem_q <= len_at(len_q, '0);
                    div_q <= DIV_RELOAD;
                end
                S_SEG: begin
                    if (div_q != '0) div_q <= div_q - DIV_W'(1);
                    if (step_go) begin
                        pos_x_q <= step_x;
                        pos_y_q <= step_y;
                        rem_q   <= rem_q - LEN_W'(1);
                        div_q   <= DIV_RELOAD;
                    end
                    // The next segment starts from this pixel, so its length is
                    // loaded in the same cycle to keep pixel spacing uniform.
                    if (advance) begin
                        idx_q <= idx_nxt;
                        rem_q <= len_at(len_q, idx_nxt);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.x     = pix_x;
    assign bus.y     = pix_y;
    assign bus.color = color_q;
    assign bus.plot  = pix_plot;
    assign bus.busy  = busy_o;
    assign bus.done  = done_o;

endmodule

// File: tb/tb_ui_polyline_drawer.sv
// Directed bench for ui_polyline_drawer: one instance at STEP_DIV=1 and one
// at STEP_DIV=4 share the command inputs but have separate start strobes.
module tb_ui_polyline_drawer;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    logic        start_a, start_b, abort, erase;
    logic [2:0]  fg_color;
    logic [7:0]  x0;
    logic [6:0]  y0;
    logic [2:0]  num_seg;
    logic [11:0] seg_dir;
    logic [19:0] seg_len;

    ui_polyline_drawer_if #(.X_W(8), .Y_W(7), .COLOR_W(3), .NUM_SEG(4), .LEN_W(5)) if_a ();
    ui_polyline_drawer_if #(.X_W(8), .Y_W(7), .COLOR_W(3), .NUM_SEG(4), .LEN_W(5)) if_b ();

    assign if_a.start = start_a;   assign if_b.start = start_b;
    assign if_a.abort = abort;     assign if_b.abort = abort;
    assign if_a.erase = erase;     assign if_b.erase = erase;
    assign if_a.fg_color = fg_color; assign if_b.fg_color = fg_color;
    assign if_a.x0 = x0;           assign if_b.x0 = x0;
    assign if_a.y0 = y0;           assign if_b.y0 = y0;
    assign if_a.num_seg = num_seg; assign if_b.num_seg = num_seg;
    assign if_a.seg_dir = seg_dir; assign if_b.seg_dir = seg_dir;
    assign if_a.seg_len = seg_len; assign if_b.seg_len = seg_len;

    ui_polyline_drawer #(.X_W(8), .Y_W(7), .COLOR_W(3), .NUM_SEG(4), .LEN_W(5), .STEP_DIV(1))
        dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
    ui_polyline_drawer #(.X_W(8), .Y_W(7), .COLOR_W(3), .NUM_SEG(4), .LEN_W(5), .STEP_DIV(4))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));

    // Observation mux onto the instance under test
    logic       sel_b;
    logic [7:0] obs_x;
    logic [6:0] obs_y;
    logic [2:0] obs_color;
    logic       obs_plot, obs_busy, obs_done;

    always_comb begin
        obs_x     = sel_b ? if_b.x     : if_a.x;
        obs_y     = sel_b ? if_b.y     : if_a.y;
        obs_color = sel_b ? if_b.color : if_a.color;
        obs_plot  = sel_b ? if_b.plot  : if_a.plot;
        obs_busy  = sel_b ? if_b.busy  : if_a.busy;
        obs_done  = sel_b ? if_b.done  : if_a.done;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Expected plots: cycle number (relative to start) and coordinates
    int         ex_c[$];
    logic [7:0] ex_x[$];
    logic [6:0] ex_y[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ex_c.delete(); ex_x.delete(); ex_y.delete();
    endtask

    task automatic add(input int c, input logic [7:0] px, input logic [6:0] py);
        ex_c.push_back(c); ex_x.push_back(px); ex_y.push_back(py);
    endtask

    task automatic start_stroke(input bit use_b);
        sel_b = use_b;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Walk cycles 1..ncyc after the start edge, checking plot/x/y/color
    // against the expected plot list and busy/done against their windows.
    task automatic run_check(input string tag, input int ncyc, input int busy_last,
                             input int done_cyc, input int abort_cyc, input int restart_cyc,
                             input logic [2:0] exp_col);
        int k;
        k = 0;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            if (cyc == abort_cyc) begin
                abort = 1'b1;
                #1;
            end
            if (cyc == restart_cyc) begin
                if (sel_b) start_b = 1'b1; else start_a = 1'b1;
                x0 = 8'd5;
                y0 = 7'd5;
            end
            if (k < ex_c.size() && ex_c[k] == cyc) begin
                check($sformatf("%s_plot_c%0d", tag, cyc), 32'(obs_plot), 32'd1);
                check($sformatf("%s_x_c%0d", tag, cyc), 32'(obs_x), 32'(ex_x[k]));
                check($sformatf("%s_y_c%0d", tag, cyc), 32'(obs_y), 32'(ex_y[k]));
                check($sformatf("%s_color_c%0d", tag, cyc), 32'(obs_color), 32'(exp_col));
                k++;
            end else begin
                check($sformatf("%s_noplot_c%0d", tag, cyc), 32'(obs_plot), 32'd0);
            end
            check($sformatf("%s_busy_c%0d", tag, cyc), 32'(obs_busy), 32'(cyc <= busy_last));
            check($sformatf("%s_done_c%0d", tag, cyc), 32'(obs_done), 32'(cyc == done_cyc));
            tick();
            abort   = 1'b0;
            start_a = 1'b0;
            start_b = 1'b0;
        end
    endtask

    task automatic load_checkmark();
        x0 = 8'd79; y0 = 7'd63; fg_color = 3'b010; num_seg = 3'd2;
        seg_dir = {3'd0, 3'd0, 3'd1, 3'd3};
        seg_len = {5'd0, 5'd0, 5'd8, 5'd4};
        clr();
        add(1, 79, 63); add(2, 78, 62); add(3, 77, 61); add(4, 76, 60); add(5, 75, 59);
        add(6, 76, 58); add(7, 77, 57); add(8, 78, 56); add(9, 79, 55);
        add(10, 80, 54); add(11, 81, 53); add(12, 82, 52); add(13, 83, 51);
    endtask

    initial begin
        sel_b = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; erase = 1'b0;
        fg_color = '0; x0 = '0; y0 = '0; num_seg = '0; seg_dir = '0; seg_len = '0;

        // Reset state, with start and abort asserted to show reset wins
        reset_n = 1'b0;
        start_a = 1'b1; start_b = 1'b1; abort = 1'b1; x0 = 8'd9; y0 = 7'd9; fg_color = 3'b111;
        tick(); tick();
        check("rst_x",     32'(if_a.x),     32'd0);
        check("rst_y",     32'(if_a.y),     32'd0);
        check("rst_color", 32'(if_a.color), 32'd0);
        check("rst_plot",  32'(if_a.plot),  32'd0);
        check("rst_busy",  32'(if_a.busy),  32'd0);
        check("rst_done",  32'(if_a.done),  32'd0);
        check("rst_b_plot", 32'(if_b.plot), 32'd0);
        check("rst_b_busy", 32'(if_b.busy), 32'd0);
        start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        reset_n = 1'b1;
        tick();
        check("idle_busy", 32'(if_a.busy), 32'd0);

        // Check mark, with an ignored restart and input changes mid-stroke
        load_checkmark();
        start_stroke(1'b0);
        run_check("chk", 15, 13, 14, 0, 5, 3'b010);

        // Erase mode: same coordinates, colour 0
        load_checkmark();
        erase = 1'b1;
        start_stroke(1'b0);
        erase = 1'b0;
        run_check("erase", 15, 13, 14, 0, 0, 3'b000);

        // Pacing on the STEP_DIV=4 instance
        x0 = 8'd10; y0 = 7'd10; fg_color = 3'b110; num_seg = 3'd1;
        seg_dir = {3'd0, 3'd0, 3'd0, 3'd0};
        seg_len = {5'd0, 5'd0, 5'd0, 5'd3};
        clr();
        add(1, 10, 10); add(5, 11, 10); add(9, 12, 10); add(13, 13, 10);
        start_stroke(1'b1);
        run_check("pace", 15, 13, 14, 0, 0, 3'b110);

        // Zero-length middle segment
        x0 = 8'd20; y0 = 7'd30; fg_color = 3'b101; num_seg = 3'd3;
        seg_dir = {3'd0, 3'd6, 3'd2, 3'd0};
        seg_len = {5'd0, 5'd2, 5'd0, 5'd2};
        clr();
        add(1, 20, 30); add(2, 21, 30); add(3, 22, 30); add(5, 22, 31); add(6, 22, 32);
        start_stroke(1'b0);
        run_check("zlen", 8, 6, 7, 0, 0, 3'b101);

        // No segments: origin only
        x0 = 8'd40; y0 = 7'd50; fg_color = 3'b011; num_seg = 3'd0;
        clr();
        add(1, 40, 50);
        start_stroke(1'b0);
        run_check("nseg0", 3, 1, 2, 0, 0, 3'b011);

        // Wrap through zero on both axes
        x0 = 8'd0; y0 = 7'd0; fg_color = 3'b001; num_seg = 3'd1;
        seg_dir = {3'd0, 3'd0, 3'd0, 3'd3};
        seg_len = {5'd0, 5'd0, 5'd0, 5'd1};
        clr();
        add(1, 0, 0); add(2, 255, 127);
        start_stroke(1'b0);
        run_check("wrap", 4, 2, 3, 0, 0, 3'b001);

        // Abort after the third plot: no further plots, no done
        load_checkmark();
        clr();
        add(1, 79, 63); add(2, 78, 62); add(3, 77, 61);
        start_stroke(1'b0);
        run_check("abort", 8, 4, 0, 4, 0, 3'b010);

        // Reset mid-stroke, then a fresh stroke
        load_checkmark();
        clr();
        add(1, 79, 63); add(2, 78, 62); add(3, 77, 61);
        start_stroke(1'b0);
        run_check("pre_rst", 3, 3, 0, 0, 0, 3'b010);
        reset_n = 1'b0;
        tick();
        check("mid_rst_x",     32'(if_a.x),     32'd0);
        check("mid_rst_y",     32'(if_a.y),     32'd0);
        check("mid_rst_color", 32'(if_a.color), 32'd0);
        check("mid_rst_plot",  32'(if_a.plot),  32'd0);
        check("mid_rst_busy",  32'(if_a.busy),  32'd0);
        check("mid_rst_done",  32'(if_a.done),  32'd0);
        reset_n = 1'b1;
        x0 = 8'd7; y0 = 7'd9; fg_color = 3'b100; num_seg = 3'd0;
        clr();
        add(1, 7, 9);
        start_stroke(1'b0);
        run_check("post_rst", 3, 1, 2, 0, 0, 3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
